// File: rtl/output_fill_2d_if.sv
// Bundle between the output-fill address generator and its surroundings:
// job configuration and control, FIFO handshake, buffer write port, status.
interface output_fill_2d_if #(
  parameter int ADDR_W = 14,
  parameter int DIM_W  = 16,
  parameter int CH_W   = 8,
  parameter int CNT_W  = 32
);
  logic              enable;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_address;
  logic [DIM_W-1:0]  cols;
  logic [DIM_W-1:0]  rows;
  logic [CH_W-1:0]   channels;
  logic [ADDR_W-1:0] row_pitch;
  logic [ADDR_W-1:0] ch_stride;
  logic              is_empty;
  logic              fifo_rd_en;
  logic [ADDR_W-1:0] c_address;
  logic              write_enable;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  words_written;

  // Side that drives the job and observes the writes.
  modport master (
    output enable, start, abort, base_address, cols, rows, channels,
           row_pitch, ch_stride, is_empty,
    input  fifo_rd_en, c_address, write_enable, busy, done, words_written
  );

  // Address generator side.
  modport slave (
    input  enable, start, abort, base_address, cols, rows, channels,
           row_pitch, ch_stride, is_empty,
    output fifo_rd_en, c_address, write_enable, busy, done, words_written
  );
endinterface

// File: rtl/output_fill_2d.sv
// Drains the PE-array output FIFO into the feature-map buffer, walking
// channel / row / column with programmable row pitch and channel stride.
// Addresses are stepped incrementally; all address math wraps at 2^ADDR_W.
module output_fill_2d #(
  parameter int ADDR_W = 14,
  parameter int DIM_W  = 16,
  parameter int CH_W   = 8,
  parameter int CNT_W  = 32
) (
  input  logic            w_clk,
  input  logic            reset,
  output_fill_2d_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    DONE_WAIT = 2'd2
  } state_t;

  state_t            state;

  // Configuration latched at start so the job is immune to input changes.
  logic [DIM_W-1:0]  cfg_cols;
  logic [DIM_W-1:0]  cfg_rows;
  logic [CH_W-1:0]   cfg_channels;
  logic [ADDR_W-1:0] cfg_row_pitch;
  logic [ADDR_W-1:0] cfg_ch_stride;

  // Position in the nest and the running base addresses.
  logic [DIM_W-1:0]  col;
  logic [DIM_W-1:0]  row;
  logic [CH_W-1:0]   ch;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] ch_base;
  logic [ADDR_W-1:0] cur;

  logic [ADDR_W-1:0] c_address_r;
  logic              write_enable_r;
  logic              busy_r;
  logic              done_r;
  logic [CNT_W-1:0]  words_written_r;

  logic              pop;
  logic              last_col;
  logic              last_row;
  logic              last_ch;
  logic              zero_job;

  // Pop the FIFO only when running, advancing, data present and not cancelled.
  assign pop = (state == RUN) && bus.enable && !bus.is_empty && !bus.abort;

  assign last_col = (col == cfg_cols - DIM_W'(1));
  assign last_row = (row == cfg_rows - DIM_W'(1));
  assign last_ch  = (ch == cfg_channels - CH_W'(1));
  assign zero_job = (bus.cols == '0) || (bus.rows == '0) || (bus.channels == '0);

  assign bus.fifo_rd_en    = pop;
  assign bus.c_address     = c_address_r;
  assign bus.write_enable  = write_enable_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.words_written = words_written_r;

  // Job sequencer: latches config, walks the nest, registers write strobe/address.
  always_ff @(posedge w_clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cfg_cols        <= '0;
      cfg_rows        <= '0;
      cfg_channels    <= '0;
      cfg_row_pitch   <= '0;
      cfg_ch_stride   <= '0;
      col             <= '0;
      row             <= '0;
      ch              <= '0;
      row_base        <= '0;
      ch_base         <= '0;
      cur             <= '0;
      c_address_r     <= '0;
      write_enable_r  <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      words_written_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          write_enable_r <= 1'b0;
          if (bus.start) begin
            cfg_cols        <= bus.cols;
            cfg_rows        <= bus.rows;
            cfg_channels    <= bus.channels;
            cfg_row_pitch   <= bus.row_pitch;
            cfg_ch_stride   <= bus.ch_stride;
            col             <= '0;
            row             <= '0;
            ch              <= '0;
            row_base        <= bus.base_address;
            ch_base         <= bus.base_address;
            cur             <= bus.base_address;
            words_written_r <= '0;
            done_r          <= 1'b0;
            busy_r          <= 1'b1;
            state           <= zero_job ? DONE_WAIT : RUN;
          end
        end

        RUN: begin
          if (bus.abort) begin
            // Cancel: partial count is kept, done is not raised.
            write_enable_r <= 1'b0;
            busy_r         <= 1'b0;
            state          <= IDLE;
          end else if (pop) begin
            // Write lands one cycle after the pop, aligned with FIFO read data.
            c_address_r     <= cur;
            write_enable_r  <= 1'b1;
            words_written_r <= words_written_r + CNT_W'(1);
            if (!last_col) begin
              col <= col + DIM_W'(1);
              cur <= cur + ADDR_W'(1);
            end else begin
              col <= '0;
              if (!last_row) begin
                row      <= row + DIM_W'(1);
                row_base <= row_base + cfg_row_pitch;
                cur      <= row_base + cfg_row_pitch;
              end else begin
                row      <= '0;
                ch       <= ch + CH_W'(1);
                ch_base  <= ch_base + cfg_ch_stride;
                row_base <= ch_base + cfg_ch_stride;
                cur      <= ch_base + cfg_ch_stride;
                if (last_ch) begin
                  state <= DONE_WAIT;
                end
              end
            end
          end else begin
            write_enable_r <= 1'b0;
          end
        end

        DONE_WAIT: begin
          write_enable_r <= 1'b0;
          done_r         <= 1'b1;
          busy_r         <= 1'b0;
          state          <= IDLE;
        end

        default: begin
          write_enable_r <= 1'b0;
          busy_r         <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/output_fill_2d.md
Name: output_fill_2d

Overview:
Parametrised write-address generator that drains an output-data FIFO into the feature-map buffer for one conv/pool layer.
Walks a 3-level nest (channel, row, column) with a programmable row pitch and channel stride, so padded or strided layouts are supported.
Pops the FIFO only when data is present, issues aligned write strobes and addresses, and reports busy, done and a word count.
Sits between the PE-array output FIFO and the output buffer BRAM.

Parameters:
ADDR_W, 14, buffer address width; all address arithmetic is modulo 2^ADDR_W
DIM_W, 16, width of the row and column dimension inputs
CH_W, 8, width of the channel-count input
CNT_W, 32, width of the words_written counter

Ports:
w_clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low
enable  in  1  global advance qualifier; low = stall
start  in  1  launch pulse, sampled only in IDLE
abort  in  1  synchronous cancel, honoured in RUN only
base_address  in  ADDR_W  address of element (ch0,row0,col0)
cols  in  DIM_W  columns per row
rows  in  DIM_W  rows per channel
channels  in  CH_W  channel count
row_pitch  in  ADDR_W  address increment between rows
ch_stride  in  ADDR_W  address increment between channels
is_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  FIFO pop, combinational
c_address  out  ADDR_W  buffer write address, registered
write_enable  out  1  buffer write strobe, registered
busy  out  1  high in RUN and DONE_WAIT
done  out  1  level; high from completion until next accepted start

Behaviour:
- Reset: state=IDLE. c_address=0, write_enable=0, busy=0, done=0, words_written=0, all counters 0. Reset mid-operation discards the job immediately.
- States: IDLE, RUN, DONE_WAIT.
- IDLE + start=1:
  - latch all config inputs; config changes afterwards are ignored until the next start
  - clear col/row/ch counters and words_written; row_base=ch_base=cur=base_address
  - done<=0, busy<=1
  - any of cols, rows or channels == 0 -> DONE_WAIT with no writes; otherwise -> RUN
- Start in RUN or DONE_WAIT is ignored.
- fifo_rd_en = (state==RUN) && enable && !is_empty && !abort.
- Each cycle with fifo_rd_en=1 (cycle N):
  - c_address<=cur and write_enable<=1, visible in cycle N+1 (1-cycle latency matching the FIFO registered read data)
  - words_written increments
- Any RUN cycle with fifo_rd_en=0: write_enable<=0 and c_address holds.
- Address stepping is incremental only (no multipliers):
  - col < cols-1: cur+=1
  - else col wraps to 0; row < rows-1: row_base+=row_pitch, cur=row_base+row_pitch
  - else row wraps to 0: ch_base+=ch_stride, cur=ch_base+ch_stride, ch+=1
- Pop of the element (channels-1, rows-1, cols-1) -> DONE_WAIT on the same edge; that final write_enable is visible in the next cycle.
- DONE_WAIT: write_enable<=0, done<=1, busy<=0, then -> IDLE. The first done=1 cycle is N+2 after the last pop. done stays high in IDLE.
- abort=1 in RUN: no pop that cycle, write_enable<=0, -> IDLE, done stays 0, words_written holds the partial count.
- abort in IDLE or DONE_WAIT is ignored.
- enable=0 or is_empty=1 in RUN: counters and address hold; no writes are lost and no duplicate writes occur.
- Address overflow past 2^ADDR_W-1 wraps to 0 with no error.
- Exactly cols*rows*channels writes per job, each address written once when row_pitch>=cols and ch_stride>=rows*row_pitch.

Test Plan:
1. base=100, cols=3, rows=2, ch=1, pitch=3, FIFO never empty -> write_enable high 6 consecutive cycles at addresses 100..105; done rises 2 cycles after the 6th pop; words_written=6.
2. base=0, cols=2, rows=2, ch=2, pitch=4, ch_stride=16 -> address sequence 0,1,4,5,16,17,20,21; busy low and done high afterwards.
3. Same as test 1 with is_empty toggling every other cycle and enable low for 3 cycles mid-job -> identical address sequence, no duplicates, no write_enable during stalls, total of 6 writes.
4. cols=0 -> no fifo_rd_en and no write_enable; done=1 two cycles after start.
5. base=16382, cols=4, rows=1, ch=1 -> addresses 16382, 16383, 0, 1.
6. abort after 3 pops -> write_enable low next cycle, state IDLE, done=0, words_written=3.
7. reset low mid-job -> all outputs 0 asynchronously; a following start runs a full job correctly.
8. start pulsed during RUN -> ignored; the original job completes unchanged.
